fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined LEGv8 processor.
- Owns the program counter and drives the instruction-memory byte address.
- Captures the returned 32-bit word into the IF/ID pipeline register, tagged with its PC and a valid bit, for the decode stage.
- Handles hazard stalls, branch redirects (with flush) and a halt when the PC runs past the end of instruction memory.

---
 rtl/lego_pkg.sv | 20 ++
 rtl/if_id_register.sv | 39 +++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lego_pkg.sv
// Shared types and constants for the LEGv8 pipeline blocks.
package lego_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // Encoding placed in IF/ID when it holds no real instruction.
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Instructions are word aligned; low address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register carrying PC, instruction word and valid bit.
// Flush takes priority over hold so a squash is never lost to a stall.
module if_id_register
  import lego_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic               d_valid,
  output logic [ADDR_W-1:0]  q_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_valid
);

  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Reset/flush clear to a bubble, hold freezes, otherwise load.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      pc_q    <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
    end else if (!hold) begin
      pc_q    <= d_pc;
      instr_q <= d_instr;
      valid_q <= d_valid;
    end
  end

  assign q_pc    = pc_q;
  assign q_instr = instr_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch/halt FSM, next-PC selection,
// and the IF/ID register feeding decode.
module fetch_stage
  import lego_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 226
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [ADDR_W-1:0]   if_id_pc,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic                if_id_valid,
  output logic                halted
);

  // A word at pc is fully inside memory iff pc <= IMEM_BYTES-4; memories
  // smaller than one word can never fetch, which also avoids the underflow.
  localparam bit              HAS_ROOM = (IMEM_BYTES >= 4);
  localparam logic [ADDR_W-1:0] LAST_PC = HAS_ROOM ? ADDR_W'(IMEM_BYTES - 4) : '0;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  fetch_state_e       state_q, state_d;
  logic               fetchable;
  logic               ifid_hold, ifid_flush;
  logic [ADDR_W-1:0]  ifid_d_pc;
  logic [INSTR_W-1:0] ifid_d_instr;
  logic               ifid_d_valid;

  assign fetchable = HAS_ROOM && (pc_q <= LAST_PC);

  // Next PC, next state and IF/ID load control; redirect > stall > fetch.
  always_comb begin
    pc_d         = pc_q;
    state_d      = state_q;
    ifid_hold    = 1'b1;
    ifid_flush   = 1'b0;
    ifid_d_pc    = pc_q;
    ifid_d_instr = imem_data;
    ifid_d_valid = 1'b0;
    if (redirect) begin
      pc_d       = align_word(redirect_target);
      state_d    = FETCH;
      ifid_flush = 1'b1;
    end else if (!stall && state_q == FETCH) begin
      ifid_hold = 1'b0;
      if (fetchable) begin
        ifid_d_valid = 1'b1;
        pc_d         = pc_q + 64'd4;
      end else begin
        // Ran off the end: leave a bubble, keep the last tagged PC, stop.
        ifid_d_pc    = if_id_pc;
        ifid_d_instr = BUBBLE_INSTR;
        state_d      = HALTED;
      end
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_register u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (ifid_hold),
    .flush   (ifid_flush),
    .d_pc    (ifid_d_pc),
    .d_instr (ifid_d_instr),
    .d_valid (ifid_d_valid),
    .q_pc    (if_id_pc),
    .q_instr (if_id_instr),
    .q_valid (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a 226-byte instance and a 60-byte
// instance share stimulus; each edge's expected outputs are queued as the
// stimulus is driven and popped after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = 64'h0;

  logic [63:0] imem_addr, if_id_pc, imem_addr60, if_id_pc60;
  logic [31:0] imem_data, if_id_instr, imem_data60, if_id_instr60;
  logic        if_id_valid, halted, if_id_valid60, halted60;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_data   = (imem_addr   < 64'd256) ? mem[imem_addr[7:2]]   : 32'hDEAD_BEEF;
  assign imem_data60 = (imem_addr60 < 64'd256) ? mem[imem_addr60[7:2]] : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(226)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted)
  );

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(60)) dut60 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr60), .imem_data(imem_data60),
    .if_id_pc(if_id_pc60), .if_id_instr(if_id_instr60), .if_id_valid(if_id_valid60),
    .halted(halted60)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } obs_t;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [63:0] tgt;
  } step_t;

  obs_t  obs, obs60;
  assign obs   = {imem_addr,   if_id_pc,   if_id_instr,   if_id_valid,   halted};
  assign obs60 = {imem_addr60, if_id_pc60, if_id_instr60, if_id_valid60, halted60};

  step_t st_q[$];
  obs_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic obs_t mk(logic [63:0] a, logic [63:0] p, logic [31:0] i,
                              logic v, logic h);
    obs_t o;
    o.addr = a; o.pc = p; o.instr = i; o.valid = v; o.halted = h;
    return o;
  endfunction

  function automatic step_t st(logic r, logic s, logic d, logic [63:0] t);
    step_t x;
    x.rst_n = r; x.stall = s; x.redir = d; x.tgt = t;
    return x;
  endfunction

  function automatic logic [31:0] word_at(logic [63:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic drive(step_t s);
    reset_n = s.rst_n; stall = s.stall; redirect = s.redir; redirect_target = s.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    st_q.push_back(st(1'b0, 1'b1, 1'b1, 64'h40)); exp_q.push_back(mk(64'h0, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b0, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'h0, 64'h0, 32'h0, 1'b0, 1'b0));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_fetch();
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0)); exp_q.push_back(mk(64'h4, 64'h0, 32'hF8428005, 1'b1, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0)); exp_q.push_back(mk(64'h8, 64'h4, 32'hF845000A, 1'b1, 1'b0));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL fetch[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    st_q.push_back(st(1'b1, 1'b1, 1'b0, 64'h0)); exp_q.push_back(mk(64'h8, 64'h4, 32'hF845000A, 1'b1, 1'b0));
    st_q.push_back(st(1'b1, 1'b1, 1'b0, 64'h0)); exp_q.push_back(mk(64'h8, 64'h4, 32'hF845000A, 1'b1, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0)); exp_q.push_back(mk(64'hC, 64'h8, 32'h8A0A00A1, 1'b1, 1'b0));
    for (int p = 'hC; p <= 'h14; p += 4) begin
      st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));
      exp_q.push_back(mk(64'(p + 4), 64'(p), word_at(64'(p)), 1'b1, 1'b0));
    end
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL stall[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_redirect();
    st_q.push_back(st(1'b1, 1'b1, 1'b1, 64'h1E)); exp_q.push_back(mk(64'h1C, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'h20, 64'h1C, 32'hF8008001, 1'b1, 1'b0));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL redirect[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    st_q.push_back(st(1'b1, 1'b0, 1'b1, 64'h10)); exp_q.push_back(mk(64'h10, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b0, 1'b1, 1'b0, 64'h0));  exp_q.push_back(mk(64'h0, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'h4, 64'h0, 32'hF8428005, 1'b1, 1'b0));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rst_mid_stall[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_end_of_mem();
    // 226 bytes: 0xDC is the last fetchable word, 0xE0 halts.
    st_q.push_back(st(1'b1, 1'b0, 1'b1, 64'hDC)); exp_q.push_back(mk(64'hDC, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'hE0, 64'hDC, word_at(64'hDC), 1'b1, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'hE0, 64'hDC, 32'h0, 1'b0, 1'b1));
    st_q.push_back(st(1'b1, 1'b1, 1'b0, 64'h0));  exp_q.push_back(mk(64'hE0, 64'hDC, 32'h0, 1'b0, 1'b1));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));  exp_q.push_back(mk(64'hE0, 64'hDC, 32'h0, 1'b0, 1'b1));
    // Top of address space: must halt, never wrap to 0.
    st_q.push_back(st(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC));
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0, 1'b0, 1'b1));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0, 1'b0, 1'b1));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL end_of_mem[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs, e);
      end
    end
  endtask

  task automatic test_small_mem_halt();
    // 60-byte instance: free-run from reset, halt at 0x3C, then restart.
    st_q.push_back(st(1'b0, 1'b0, 1'b0, 64'h0)); exp_q.push_back(mk(64'h0, 64'h0, 32'h0, 1'b0, 1'b0));
    for (int p = 0; p <= 'h38; p += 4) begin
      st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));
      exp_q.push_back(mk(64'(p + 4), 64'(p), word_at(64'(p)), 1'b1, 1'b0));
    end
    for (int n = 0; n < 6; n++) begin
      st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0));
      exp_q.push_back(mk(64'h3C, 64'h38, 32'h0, 1'b0, 1'b1));
    end
    st_q.push_back(st(1'b1, 1'b0, 1'b1, 64'h0)); exp_q.push_back(mk(64'h0, 64'h0, 32'h0, 1'b0, 1'b0));
    st_q.push_back(st(1'b1, 1'b0, 1'b0, 64'h0)); exp_q.push_back(mk(64'h4, 64'h0, 32'hF8428005, 1'b1, 1'b0));
    for (int k = 0; st_q.size() > 0; k++) begin
      obs_t e;
      drive(st_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs60 !== e) begin
        n_bad++;
        $display("FAIL small_mem[%0d]: got %h required %h (addr,pc,instr,valid,halted)", k, obs60, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]  = 32'hF8428005;
    mem[1]  = 32'hF845000A;
    mem[2]  = 32'h8A0A00A1;
    mem[3]  = 32'h8B0A00A2;
    mem[4]  = 32'hCB0A00A3;
    mem[5]  = 32'hAA0A00A4;
    mem[6]  = 32'hB40000A5;
    mem[7]  = 32'hF8008001;
    mem[14] = 32'hF8048004;

    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_reset_mid_stall();
    test_end_of_mem();
    test_small_mem_halt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
